// File: rtl/flit_uart_serializer.sv
// flit_uart_serializer
//   Transmit side of the inter-device UART link. Accepts one flit over a valid/ready
//   handshake and shifts it out as FLIT_WIDTH/8 UART frames, byte 0 (flit[7:0]) first,
//   each byte LSB first. The next flit is held off until the last stop bit has finished.
//
//   Handshake: a flit transfers on a rising nocclk edge where flit_in_valid and
//   flit_in_ready are both high. flit_in_ready is high only in IDLE and is purely
//   combinational from the state register. flit_in is sampled only on that edge, and
//   valid seen while ready is low has no effect.
//
//   Optional feature macro: FLIT_UART_PARITY_EN
//     defined   : 8E1 frames (even parity bit inserted after the data bits)
//     undefined : 8N1 frames (no parity state or parity logic)
module flit_uart_serializer #(
    parameter int FLIT_WIDTH   = 128,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  nocclk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] flit_in,
    input  logic                  flit_in_valid,
    output logic                  flit_in_ready,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  flit_done,
    output logic [2:0]            state_dbg_o
);

    localparam int NUM_BYTES = FLIT_WIDTH / 8;
    localparam int BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

    // Reject parameter combinations the framing logic cannot represent.
    generate
        if ((FLIT_WIDTH % 8) != 0 || FLIT_WIDTH < 8) begin : g_bad_width
            $error("flit_uart_serializer: FLIT_WIDTH must be a non-zero multiple of 8");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("flit_uart_serializer: CLKS_PER_BIT must be >= 2");
        end
    endgenerate

`ifdef FLIT_UART_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t                  state_q,  state_d;
    logic [BAUD_W-1:0]       baud_q,   baud_d;
    logic [2:0]              bit_q,    bit_d;
    logic [BYTE_W-1:0]       byte_q,   byte_d;
    logic [FLIT_WIDTH-1:0]   sr_q,     sr_d;
    logic                    tx_q,     tx_d;
`ifdef FLIT_UART_PARITY_EN
    logic                    par_q,    par_d;
`endif

    logic accept;
    logic baud_end;

    assign flit_in_ready = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign uart_tx       = tx_q;
    assign state_dbg_o   = state_q;
    assign accept        = flit_in_valid && flit_in_ready;
    assign baud_end      = (baud_q == BAUD_LAST);

    // State, counters, shift register and the registered line level.
    always_ff @(posedge nocclk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            sr_q    <= '0;
            tx_q    <= 1'b1;
`ifdef FLIT_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sr_q    <= sr_d;
            tx_q    <= tx_d;
`ifdef FLIT_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic; tx_d is the line level for the state being entered so the
    // registered output changes on the same edge as the state.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sr_d      = sr_q;
        tx_d      = tx_q;
        flit_done = 1'b0;
`ifdef FLIT_UART_PARITY_EN
        par_d     = par_q;
`endif

        // Bit-period counter runs in every non-idle state and wraps at each bit boundary.
        if (state_q != S_IDLE) begin
            baud_d = baud_end ? '0 : baud_q + BAUD_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (accept) begin
                    state_d = S_START;
                    sr_d    = flit_in;
                    byte_d  = '0;
                    tx_d    = 1'b0;
                end
            end

            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = sr_q[0];
`ifdef FLIT_UART_PARITY_EN
                    // Parity of the whole byte, taken before any of it is shifted out.
                    par_d   = ^sr_q[7:0];
`endif
                end
            end

            S_DATA: begin
                if (baud_end) begin
                    sr_d = {1'b0, sr_q[FLIT_WIDTH-1:1]};
                    if (bit_q == 3'd7) begin
`ifdef FLIT_UART_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = sr_q[1];
                    end
                end
            end

`ifdef FLIT_UART_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (baud_end) begin
                    if (byte_q == BYTE_LAST) begin
                        state_d   = S_IDLE;
                        tx_d      = 1'b1;
                        flit_done = 1'b1;
                    end else begin
                        // Next byte starts immediately; no idle gap between frames.
                        byte_d  = byte_q + BYTE_W'(1);
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_flit_uart_serializer.sv
// Bench for flit_uart_serializer: main instance at FLIT_WIDTH=128, CLKS_PER_BIT=4,
// plus a small instance at FLIT_WIDTH=16, CLKS_PER_BIT=2.
module tb_flit_uart_serializer;

  localparam int W  = 128;
  localparam int C  = 4;
  localparam int NB = W / 8;
`ifdef FLIT_UART_PARITY_EN
  localparam int F        = 11;
  localparam int FLIT_CYC = 704;
  localparam int S_CYC    = 44;
`else
  localparam int F        = 10;
  localparam int FLIT_CYC = 640;
  localparam int S_CYC    = 40;
`endif
  localparam int SC = 2;

  // ---------------- clock / reset ----------------
  logic nocclk;
  logic rst;

  initial begin
    nocclk = 1'b0;
    forever #5 nocclk = ~nocclk;
  end

  // ---------------- DUT signals ----------------
  logic [W-1:0] flit_in;
  logic         flit_in_valid;
  logic         flit_in_ready;
  logic         uart_tx;
  logic         busy;
  logic         flit_done;
  logic [2:0]   state_dbg;

  logic [15:0]  s_flit_in;
  logic         s_flit_in_valid;
  logic         s_flit_in_ready;
  logic         s_uart_tx;
  logic         s_busy;
  logic         s_flit_done;
  logic [2:0]   s_state_dbg;

  flit_uart_serializer #(.FLIT_WIDTH(W), .CLKS_PER_BIT(C)) u_dut (
    .nocclk        (nocclk),
    .rst           (rst),
    .flit_in       (flit_in),
    .flit_in_valid (flit_in_valid),
    .flit_in_ready (flit_in_ready),
    .uart_tx       (uart_tx),
    .busy          (busy),
    .flit_done     (flit_done),
    .state_dbg_o   (state_dbg)
  );

  flit_uart_serializer #(.FLIT_WIDTH(16), .CLKS_PER_BIT(SC)) u_small (
    .nocclk        (nocclk),
    .rst           (rst),
    .flit_in       (s_flit_in),
    .flit_in_valid (s_flit_in_valid),
    .flit_in_ready (s_flit_in_ready),
    .uart_tx       (s_uart_tx),
    .busy          (s_busy),
    .flit_done     (s_flit_done),
    .state_dbg_o   (s_state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Results of the most recent xfer() call.
  logic [W-1:0] r_got;
  logic [9:0]   r_frame0;   // byte 0 frame: start, 8 data bits, stop (parity excluded)
  logic         r_par0;
  int           r_done_cyc;
  int           r_done_cnt;
  int           r_rdy_cyc;
  int           r_tx_bad;
  int           r_flag_bad;

  // Driver + line monitor. Called at a negedge with the DUT ready. Records the line for
  // every cycle of the flit plus one idle cycle, then decodes frames from mid-bit samples.
  // hold: keep valid high and present next_f for a back-to-back transfer.
  // bp_cyc: if nonzero, pulse valid with bp_f during that cycle of the flit.
  task automatic xfer(input logic [W-1:0] f, input bit hold, input logic [W-1:0] next_f,
                      input int bp_cyc, input logic [W-1:0] bp_f);
    logic line [1:FLIT_CYC+1];
    int   p, b, j, k0;
    logic s;
    r_got = '0; r_frame0 = '0; r_par0 = 1'b0;
    r_done_cyc = 0; r_done_cnt = 0; r_rdy_cyc = 0; r_tx_bad = 0; r_flag_bad = 0;
    if (!flit_in_ready) r_flag_bad++;
    flit_in       = f;
    flit_in_valid = 1'b1;
    @(negedge nocclk);
    if (hold) flit_in = next_f;
    else begin
      flit_in_valid = 1'b0;
      flit_in       = ~f;
    end
    for (int k = 1; k <= FLIT_CYC + 1; k++) begin
      line[k] = uart_tx;
      if (flit_done) begin
        r_done_cnt++;
        if (r_done_cyc == 0) r_done_cyc = k;
      end
      if (flit_in_ready && r_rdy_cyc == 0) r_rdy_cyc = k;
      if (k <= FLIT_CYC && (!busy || flit_in_ready)) r_flag_bad++;
      if (k == FLIT_CYC + 1 && (busy || !flit_in_ready || flit_done)) r_flag_bad++;
      if (flit_done && flit_in_ready) r_flag_bad++;
      if (bp_cyc != 0 && !hold) begin
        if (k == bp_cyc) begin
          flit_in_valid = 1'b1;
          flit_in       = bp_f;
        end else if (k == bp_cyc + 1) begin
          flit_in_valid = 1'b0;
        end
      end
      if (k <= FLIT_CYC) @(negedge nocclk);
    end
    for (p = 0; p < NB * F; p++) begin
      k0 = p * C;
      s  = line[k0 + C / 2 + 1];
      for (int c = 1; c <= C; c++) if (line[k0 + c] !== s) r_tx_bad++;
      b = p / F;
      j = p % F;
      if (j == 0) begin
        if (s !== 1'b0) r_tx_bad++;
      end else if (j <= 8) begin
        r_got[b * 8 + j - 1] = s;
      end else if (j == F - 1) begin
        if (s !== 1'b1) r_tx_bad++;
      end
`ifdef FLIT_UART_PARITY_EN
      else begin
        if (s !== ^f[b * 8 +: 8]) r_tx_bad++;
        if (b == 0) r_par0 = s;
      end
`endif
      if (b == 0 && j <= 8) r_frame0[j] = s;
      if (b == 0 && j == F - 1) r_frame0[9] = s;
    end
  endtask

  task automatic check_xfer(input string tag, input logic [W-1:0] f);
    check({tag, "_data"}, r_got, f);
    check({tag, "_done_cyc"}, W'(r_done_cyc), W'(FLIT_CYC));
    check({tag, "_done_cnt"}, W'(r_done_cnt), W'(1));
    check({tag, "_tx_timing"}, W'(r_tx_bad), W'(0));
    check({tag, "_flags"}, W'(r_flag_bad), W'(0));
  endtask

  typedef struct {
    logic [W-1:0] flit;
    logic [9:0]   frame0;   // hand-derived: bit0 start .. bit9 stop
    logic         par0;     // even parity of byte 0
  } vec_t;

  vec_t vecs [6];

  // Safety net so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int           bad;
    logic [19:0]  sline_dummy;
    logic         sline [1:S_CYC+1];
    logic [15:0]  s_got;
    int           s_done_cyc, s_bad, p, j, b;
    logic         s;

    vecs[0] = '{128'h0F,                                  10'h21E, 1'b0};
    vecs[1] = '{128'h07,                                  10'h20E, 1'b1};
    vecs[2] = '{128'h03,                                  10'h206, 1'b0};
    vecs[3] = '{128'h0123456789ABCDEF_FEDCBA9876543210,   10'h220, 1'b1};
    vecs[4] = '{{128{1'b1}},                              10'h3FE, 1'b0};
    vecs[5] = '{128'h80000000000000000000000000000080,    10'h300, 1'b1};
    sline_dummy = '0;

    rst = 1'b1;
    flit_in = '0; flit_in_valid = 1'b0;
    s_flit_in = '0; s_flit_in_valid = 1'b0;
    #1;
    check("reset_tx",    W'(uart_tx),       W'(1));
    check("reset_ready", W'(flit_in_ready), W'(1));
    check("reset_busy",  W'(busy),          W'(0));
    check("reset_done",  W'(flit_done),     W'(0));
    repeat (3) @(negedge nocclk);
    rst = 1'b0;
    @(negedge nocclk);

    // Table-driven single flits.
    for (int i = 0; i < 6; i++) begin
      xfer(vecs[i].flit, 1'b0, '0, 0, '0);
      check_xfer($sformatf("vec%0d", i), vecs[i].flit);
      check($sformatf("vec%0d_frame0", i), W'(r_frame0), W'(vecs[i].frame0));
`ifdef FLIT_UART_PARITY_EN
      check($sformatf("vec%0d_parity0", i), W'(r_par0), W'(vecs[i].par0));
`endif
      check($sformatf("vec%0d_idle_ready", i), W'(r_rdy_cyc), W'(FLIT_CYC + 1));
    end

    // Back-to-back: valid held high across two flits.
    xfer(128'hDEADBEEF_00112233_44556677_8899AABB, 1'b1,
         128'h0BADF00D_CAFEBABE_13579BDF_2468ACE0, 0, '0);
    check_xfer("b2b_a", 128'hDEADBEEF_00112233_44556677_8899AABB);
    check("b2b_accept_gap", W'(r_rdy_cyc), W'(FLIT_CYC + 1));
    xfer(128'h0BADF00D_CAFEBABE_13579BDF_2468ACE0, 1'b0, '0, 0, '0);
    check_xfer("b2b_b", 128'h0BADF00D_CAFEBABE_13579BDF_2468ACE0);

    // Backpressure: valid pulsed mid-flit with different data.
    xfer(128'h5555AAAA_12345678_9ABCDEF0_0F0F0F0F, 1'b0, '0, 100, {128{1'b1}});
    check_xfer("bp", 128'h5555AAAA_12345678_9ABCDEF0_0F0F0F0F);
    bad = 0;
    repeat (5) begin
      @(negedge nocclk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || flit_in_ready !== 1'b1) bad++;
    end
    check("bp_no_side_effect", W'(bad), W'(0));

    // Asynchronous reset in the middle of a data bit.
    flit_in = '0; flit_in_valid = 1'b1;
    @(negedge nocclk);
    flit_in_valid = 1'b0;
    repeat (17) @(negedge nocclk);
    check("rst_pre_tx_low", W'(uart_tx), W'(0));
    check("rst_pre_busy",   W'(busy),    W'(1));
    #2 rst = 1'b1;
    #1;
    check("rst_async_tx",    W'(uart_tx),       W'(1));
    check("rst_async_ready", W'(flit_in_ready), W'(1));
    check("rst_async_busy",  W'(busy),          W'(0));
    @(negedge nocclk);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge nocclk);
      if (uart_tx !== 1'b1 || busy !== 1'b0 || flit_done !== 1'b0) bad++;
    end
    check("rst_after_idle", W'(bad), W'(0));
    xfer(128'hC3, 1'b0, '0, 0, '0);
    check_xfer("rst_recover", 128'hC3);

    // Small instance: 16-bit flit, 2 clocks per bit.
    s_flit_in = 16'hA55A; s_flit_in_valid = 1'b1;
    @(negedge nocclk);
    s_flit_in_valid = 1'b0;
    s_done_cyc = 0;
    for (int k = 1; k <= S_CYC + 1; k++) begin
      sline[k] = s_uart_tx;
      if (s_flit_done && s_done_cyc == 0) s_done_cyc = k;
      if (k <= S_CYC) @(negedge nocclk);
    end
    s_got = '0; s_bad = 0;
    for (p = 0; p < 2 * F; p++) begin
      s = sline[p * SC + SC / 2 + 1];
      if (sline[p * SC + 1] !== s) s_bad++;
      b = p / F;
      j = p % F;
      if (j == 0 && s !== 1'b0) s_bad++;
      else if (j >= 1 && j <= 8) s_got[b * 8 + j - 1] = s;
      else if (j == F - 1 && s !== 1'b1) s_bad++;
    end
    check("small_byte0",    W'(s_got[7:0]),  W'(8'h5A));
    check("small_byte1",    W'(s_got[15:8]), W'(8'hA5));
    check("small_done_cyc", W'(s_done_cyc),  W'(S_CYC));
    check("small_framing",  W'(s_bad),       W'(0));
    check("small_idle",     W'({s_flit_in_ready, s_busy, s_uart_tx}), W'(3'b101));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
